// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte/half/word requests onto a word-wide RAM with
// read-modify-write for sub-word stores. Optional MEM_ACCESS_ADDR_CHECK_EN rejects out-of-range addresses.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;

  logic [1:0]        state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_wword;

  logic              accept;
  logic              misaligned;
  logic              addr_err;
  logic              reject;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

`ifdef MEM_ACCESS_ADDR_CHECK_EN
  assign addr_err = |req_addr[31:ADDR_W+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign addr_err       = 1'b0;
`endif

  assign reject = misaligned || addr_err;

  // RAM-side strobes depend only on state and the captured request.
  assign mem_rd    = (state == RD);
  assign mem_wr    = (state == WR);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wword;

  always_comb begin
    byte_v   = mem_rdata[{r_lane, 3'b000} +: 8];
    half_v   = mem_rdata[{r_lane[1], 4'b0000} +: 16];
    load_ext = mem_rdata;
    case (r_size)
      2'b00:   load_ext = {{(DATA_W-8){~r_unsigned & byte_v[7]}}, byte_v};
      2'b01:   load_ext = {{(DATA_W-16){~r_unsigned & half_v[15]}}, half_v};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    case (r_size)
      2'b00:   merged[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
      2'b01:   merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: merged = r_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wword    <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (reject) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_we       <= req_we;
              r_size     <= req_size;
              r_unsigned <= req_unsigned;
              r_lane     <= req_addr[1:0];
              r_addr     <= req_addr[ADDR_W+1:2];
              r_wdata    <= req_wdata;
              if (req_we && req_size[1]) begin
                r_wword <= req_wdata;
                state   <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (r_we) begin
            r_wword <= merged;
            state   <= WR;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_ext;
            state     <= IDLE;
          end
        end
        WR: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
